rx_symbol_align_ctrl: RTL and testbench

- Comma-based symbol alignment controller placed directly after the receive serial-to-parallel converter, in the parallel-symbol clock domain.
- Scans the unaligned 10-bit word stream for K28.5 at any of 10 bit offsets and sequences a search/candidate/lock state machine.
- Drives the barrel-select offset and outputs aligned symbols.
- Requests a CDR restart when no comma is found within a timeout.

---
 rtl/rx_symbol_align_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_rx_symbol_align_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_symbol_align_ctrl.sv
// K28.5 comma alignment controller for the 10-bit parallel receive stream.
// Define RX_ALIGN_LOCK_STATS_EN to add the Lock_Loss_Count statistics output.
module rx_symbol_align_ctrl #(
  parameter int DATA_WIDTH     = 10,
  parameter int LOCK_COUNT     = 3,
  parameter int ERR_LIMIT      = 4,
  parameter int SEARCH_TIMEOUT = 1024
) (
  input  logic                  CLK,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  Data_valid,
  input  logic                  Align_En,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  Data_out_valid,
  output logic                  K285,
  output logic [3:0]            Offset,
  output logic                  Symbol_Lock,
`ifdef RX_ALIGN_LOCK_STATS_EN
  output logic                  Cdr_Restart,
  output logic [15:0]           Lock_Loss_Count
`else
  output logic                  Cdr_Restart
`endif
);

  localparam logic [DATA_WIDTH-1:0] COMMA_NEG   = 10'b0011111010;
  localparam logic [DATA_WIDTH-1:0] COMMA_POS   = 10'b1100000101;
  localparam logic [3:0]            LOCK_MAX    = 4'(LOCK_COUNT);
  localparam logic [3:0]            ERR_MAX     = 4'(ERR_LIMIT);
  localparam logic [15:0]           TIMEOUT_MAX = 16'(SEARCH_TIMEOUT);

  typedef enum logic [1:0] {
    SEARCH    = 2'd0,
    CANDIDATE = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   prev_q, prev_d;
  logic [3:0]              offset_q, offset_d;
  logic [3:0]              cand_off_q, cand_off_d;
  logic [3:0]              lock_cnt_q, lock_cnt_d;
  logic [3:0]              err_cnt_q, err_cnt_d;
  logic [15:0]             timeout_q, timeout_d;
  logic                    cdr_restart_q, cdr_restart_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    data_out_valid_q, data_out_valid_d;
  logic                    k285_q, k285_d;

  // The LSB of Data_in never starts a candidate, so the window drops it.
  logic [2*DATA_WIDTH-2:0] window;
  logic [DATA_WIDTH-1:0]   cand [DATA_WIDTH];
  logic [DATA_WIDTH-1:0]   is_comma;
  logic                    hit;
  logic [3:0]              hit_off;
  logic [DATA_WIDTH-1:0]   sel_cand;
  logic                    sel_comma;

  always_comb begin
    window    = {prev_q, Data_in[DATA_WIDTH-1:1]};
    hit       = 1'b0;
    hit_off   = '0;
    sel_cand  = '0;
    sel_comma = 1'b0;
    for (int k = 0; k < DATA_WIDTH; k++) begin
      cand[k]     = window[2*DATA_WIDTH-2-k -: DATA_WIDTH];
      is_comma[k] = (cand[k] == COMMA_NEG) || (cand[k] == COMMA_POS);
    end
    // Scanning downward lets the lowest matching offset win.
    for (int k = DATA_WIDTH-1; k >= 0; k--) begin
      if (is_comma[k]) begin
        hit     = 1'b1;
        hit_off = 4'(k);
      end
    end
    for (int k = 0; k < DATA_WIDTH; k++) begin
      if (offset_q == 4'(k)) begin
        sel_cand  = cand[k];
        sel_comma = is_comma[k];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q          <= SEARCH;
      prev_q           <= '0;
      offset_q         <= '0;
      cand_off_q       <= '0;
      lock_cnt_q       <= '0;
      err_cnt_q        <= '0;
      timeout_q        <= '0;
      cdr_restart_q    <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      k285_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      prev_q           <= prev_d;
      offset_q         <= offset_d;
      cand_off_q       <= cand_off_d;
      lock_cnt_q       <= lock_cnt_d;
      err_cnt_q        <= err_cnt_d;
      timeout_q        <= timeout_d;
      cdr_restart_q    <= cdr_restart_d;
      data_out_q       <= data_out_d;
      data_out_valid_q <= data_out_valid_d;
      k285_q           <= k285_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    offset_d      = offset_q;
    cand_off_d    = cand_off_q;
    lock_cnt_d    = lock_cnt_q;
    err_cnt_d     = err_cnt_q;
    timeout_d     = timeout_q;
    cdr_restart_d = 1'b0;
    prev_d        = Data_valid ? Data_in : prev_q;
    if (Data_valid && Align_En) begin
      unique case (state_q)
        SEARCH: begin
          if (hit) begin
            cand_off_d = hit_off;
            lock_cnt_d = 4'd1;
            timeout_d  = '0;
            if (LOCK_COUNT == 1) begin
              state_d   = LOCKED;
              offset_d  = hit_off;
              err_cnt_d = '0;
            end else begin
              state_d = CANDIDATE;
            end
          end else if (timeout_q + 16'd1 == TIMEOUT_MAX) begin
            cdr_restart_d = 1'b1;
            timeout_d     = '0;
          end else begin
            timeout_d = timeout_q + 16'd1;
          end
        end
        CANDIDATE: begin
          if (hit && hit_off == cand_off_q) begin
            if (lock_cnt_q + 4'd1 == LOCK_MAX) begin
              state_d    = LOCKED;
              offset_d   = cand_off_q;
              err_cnt_d  = '0;
              lock_cnt_d = LOCK_MAX;
            end else begin
              lock_cnt_d = lock_cnt_q + 4'd1;
            end
          end else if (hit) begin
            cand_off_d = hit_off;
            lock_cnt_d = 4'd1;
          end
        end
        LOCKED: begin
          if (hit && hit_off == offset_q) begin
            err_cnt_d = '0;
          end else if (hit) begin
            if (err_cnt_q + 4'd1 == ERR_MAX) begin
              state_d   = SEARCH;
              timeout_d = '0;
              err_cnt_d = '0;
            end else begin
              err_cnt_d = err_cnt_q + 4'd1;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // The datapath keeps running while alignment is frozen.
  always_comb begin
    data_out_d       = data_out_q;
    k285_d           = k285_q;
    data_out_valid_d = 1'b0;
    if (Data_valid) begin
      data_out_d       = sel_cand;
      k285_d           = sel_comma;
      data_out_valid_d = 1'b1;
    end
  end

  always_comb begin
    Data_out       = data_out_q;
    Data_out_valid = data_out_valid_q;
    K285           = k285_q;
    Offset         = offset_q;
    Symbol_Lock    = (state_q == LOCKED);
    Cdr_Restart    = cdr_restart_q;
  end

`ifdef RX_ALIGN_LOCK_STATS_EN
  logic [15:0] lock_loss_q, lock_loss_d;
  logic        lock_lost;

  always_comb begin
    lock_lost   = (state_q == LOCKED) && (state_d == SEARCH);
    lock_loss_d = lock_loss_q;
    if (lock_lost && lock_loss_q != 16'hFFFF) begin
      lock_loss_d = lock_loss_q + 16'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      lock_loss_q <= '0;
    end else begin
      lock_loss_q <= lock_loss_d;
    end
  end

  assign Lock_Loss_Count = lock_loss_q;
`endif

endmodule

// File: tb/tb_rx_symbol_align_ctrl.sv
// Directed bench for rx_symbol_align_ctrl: builds bit-shifted comma streams
// and checks lock, loss, timeout, freeze and reset behaviour.
module tb_rx_symbol_align_ctrl;

  localparam logic [9:0] COMMA = 10'b0011111010;
  localparam logic [9:0] FILL  = 10'b1010101010;

  logic       CLK = 1'b0;
  logic       Rst = 1'b1;
  logic [9:0] Data_in = '0;
  logic       Data_valid = 1'b0;
  logic       Align_En = 1'b1;
  logic [9:0] Data_out;
  logic       Data_out_valid;
  logic       K285;
  logic [3:0] Offset;
  logic       Symbol_Lock;
  logic       Cdr_Restart;
`ifdef RX_ALIGN_LOCK_STATS_EN
  logic [15:0] lock_loss_count;
`endif

  int         n_checks = 0;
  int         n_fail = 0;
  logic [9:0] last_sym = FILL;

  rx_symbol_align_ctrl #(
    .DATA_WIDTH    (10),
    .LOCK_COUNT    (3),
    .ERR_LIMIT     (4),
    .SEARCH_TIMEOUT(16)
  ) dut (
    .CLK            (CLK),
    .Rst            (Rst),
    .Data_in        (Data_in),
    .Data_valid     (Data_valid),
    .Align_En       (Align_En),
    .Data_out       (Data_out),
    .Data_out_valid (Data_out_valid),
    .K285           (K285),
    .Offset         (Offset),
    .Symbol_Lock    (Symbol_Lock),
`ifdef RX_ALIGN_LOCK_STATS_EN
    .Cdr_Restart    (Cdr_Restart),
    .Lock_Loss_Count(lock_loss_count)
`else
    .Cdr_Restart    (Cdr_Restart)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Sends one symbol of a stream delayed by 'shift' bits, so its comma lands at that offset.
  task automatic applyStimulus(input logic [9:0] sym, input int shift);
    logic [19:0] pair;
    pair       = {last_sym, sym} >> shift;
    Data_in    = pair[9:0];
    Data_valid = 1'b1;
    last_sym   = sym;
    @(posedge CLK);
    #1;
  endtask

  task automatic sendComma(input int shift);
    applyStimulus(COMMA, shift);
    applyStimulus(FILL, shift);
  endtask

  task automatic idleCycle();
    Data_valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    Rst        = 1'b1;
    Align_En   = 1'b1;
    Data_valid = 1'b0;
    @(posedge CLK);
    #1;
    Rst      = 1'b0;
    last_sym = FILL;
  endtask

  initial begin
    $display("[TB] start");
    doReset();
    checkOutput("rst_data_out", Data_out, 10'h0);
    checkOutput("rst_valid", Data_out_valid, 1'b0);
    checkOutput("rst_k285", K285, 1'b0);
    checkOutput("rst_offset", Offset, 4'd0);
    checkOutput("rst_lock", Symbol_Lock, 1'b0);
    checkOutput("rst_cdr", Cdr_Restart, 1'b0);

    // Lock on a 3-bit shifted stream with a comma every 5th word.
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < 4; j++) applyStimulus(FILL, 3);
      applyStimulus(COMMA, 3);
    end
    for (int j = 0; j < 4; j++) applyStimulus(FILL, 3);
    applyStimulus(COMMA, 3);
    checkOutput("t1_lock_pre", Symbol_Lock, 1'b0);
    applyStimulus(FILL, 3);
    checkOutput("t1_lock", Symbol_Lock, 1'b1);
    checkOutput("t1_offset", Offset, 4'd3);
    for (int j = 0; j < 3; j++) applyStimulus(FILL, 3);
    applyStimulus(COMMA, 3);
    checkOutput("t1_fill_out", Data_out, FILL);
    checkOutput("t1_fill_k", K285, 1'b0);
    applyStimulus(FILL, 3);
    checkOutput("t1_comma_out", Data_out, COMMA);
    checkOutput("t1_comma_k", K285, 1'b1);
    checkOutput("t1_comma_valid", Data_out_valid, 1'b1);
    checkOutput("t1_still_lock", Symbol_Lock, 1'b1);

    // Candidate restarts when the comma moves from offset 3 to 7.
    doReset();
    applyStimulus(FILL, 3);
    sendComma(3);
    applyStimulus(FILL, 7);
    sendComma(7);
    applyStimulus(FILL, 7);
    sendComma(7);
    checkOutput("t2_lock_pre", Symbol_Lock, 1'b0);
    applyStimulus(FILL, 7);
    sendComma(7);
    checkOutput("t2_lock", Symbol_Lock, 1'b1);
    checkOutput("t2_offset", Offset, 4'd7);

    // Lock at 2, then four wrong-offset commas drop the lock; relock at 5 and lose it again.
    doReset();
`ifdef RX_ALIGN_LOCK_STATS_EN
    checkOutput("t3_stats_rst", lock_loss_count, 16'd0);
`endif
    applyStimulus(FILL, 2);
    for (int j = 0; j < 3; j++) sendComma(2);
    checkOutput("t3_lock", Symbol_Lock, 1'b1);
    checkOutput("t3_offset", Offset, 4'd2);
    applyStimulus(FILL, 5);
    for (int j = 0; j < 3; j++) sendComma(5);
    checkOutput("t3_lock_err3", Symbol_Lock, 1'b1);
    sendComma(5);
    checkOutput("t3_lock_err4", Symbol_Lock, 1'b0);
    checkOutput("t3_offset_kept", Offset, 4'd2);
`ifdef RX_ALIGN_LOCK_STATS_EN
    checkOutput("t3_stats_1", lock_loss_count, 16'd1);
`endif
    for (int j = 0; j < 3; j++) sendComma(5);
    checkOutput("t3_relock", Symbol_Lock, 1'b1);
    checkOutput("t3_relock_off", Offset, 4'd5);
    applyStimulus(FILL, 2);
    for (int j = 0; j < 4; j++) sendComma(2);
    checkOutput("t3_loss2", Symbol_Lock, 1'b0);
`ifdef RX_ALIGN_LOCK_STATS_EN
    checkOutput("t3_stats_2", lock_loss_count, 16'd2);
`endif

    // A correct comma between wrong ones clears the error count.
    doReset();
    applyStimulus(FILL, 2);
    for (int j = 0; j < 3; j++) sendComma(2);
    applyStimulus(FILL, 5);
    for (int j = 0; j < 3; j++) sendComma(5);
    applyStimulus(FILL, 2);
    sendComma(2);
    applyStimulus(FILL, 5);
    sendComma(5);
    checkOutput("t3v_keep", Symbol_Lock, 1'b1);
    sendComma(5);
    sendComma(5);
    checkOutput("t3v_keep3", Symbol_Lock, 1'b1);

    // Comma-free data: restart pulse every 16 valid words; gaps do not count.
    doReset();
    for (int i = 1; i <= 17; i++) begin
      applyStimulus(FILL, 0);
      checkOutput($sformatf("t4_cdr_%0d", i), Cdr_Restart, (i == 16) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      idleCycle();
      checkOutput("t4_gap_valid", Data_out_valid, 1'b0);
      checkOutput("t4_gap_cdr", Cdr_Restart, 1'b0);
    end
    checkOutput("t4_gap_hold", Data_out, FILL);
    for (int i = 18; i <= 32; i++) begin
      applyStimulus(FILL, 0);
      checkOutput($sformatf("t4_cdr_%0d", i), Cdr_Restart, (i == 32) ? 1'b1 : 1'b0);
    end

    // Freeze mid-candidate: commas keep coming but no progress until re-enabled.
    doReset();
    applyStimulus(FILL, 4);
    sendComma(4);
    Align_En = 1'b0;
    for (int j = 0; j < 3; j++) sendComma(4);
    checkOutput("t5_frozen_lock", Symbol_Lock, 1'b0);
    checkOutput("t5_frozen_off", Offset, 4'd0);
    checkOutput("t5_frozen_valid", Data_out_valid, 1'b1);
    Align_En = 1'b1;
    sendComma(4);
    checkOutput("t5_resume2", Symbol_Lock, 1'b0);
    sendComma(4);
    checkOutput("t5_resume3", Symbol_Lock, 1'b1);
    checkOutput("t5_offset", Offset, 4'd4);

    // Reset while locked with valid data present.
    sendComma(4);
    checkOutput("t6_pre_out", Data_out, COMMA);
    Rst        = 1'b1;
    Data_in    = 10'b1010011111;
    Data_valid = 1'b1;
    @(posedge CLK);
    #1;
    Rst = 1'b0;
    last_sym = FILL;
    checkOutput("t6_data_out", Data_out, 10'h0);
    checkOutput("t6_valid", Data_out_valid, 1'b0);
    checkOutput("t6_k285", K285, 1'b0);
    checkOutput("t6_offset", Offset, 4'd0);
    checkOutput("t6_lock", Symbol_Lock, 1'b0);
    checkOutput("t6_cdr", Cdr_Restart, 1'b0);
`ifdef RX_ALIGN_LOCK_STATS_EN
    checkOutput("t6_stats", lock_loss_count, 16'd0);
`endif
    applyStimulus(FILL, 4);
    sendComma(4);
    sendComma(4);
    checkOutput("t6_search2", Symbol_Lock, 1'b0);
    sendComma(4);
    checkOutput("t6_relock", Symbol_Lock, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
